elbeth_mem_access_unit: RTL and testbench

//  MEM-stage data-memory access unit; consumes mem_en/rw/size/sign fields produced by control decode.

---
 rtl/elbeth_mem_access_unit_pkg.sv | 20 ++
 rtl/elbeth_mem_access_unit_load_extender.sv | 26 ++
 rtl/elbeth_mem_access_unit.sv | 188 ++++++++++++++++++
 tb/tb_elbeth_mem_access_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/elbeth_mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage access unit: size codes, FSM states and a size-legality helper.
package elbeth_mem_access_unit_pkg;

  localparam logic [3:0] MEM_SIZE_NONE = 4'b0000;
  localparam logic [3:0] MEM_SIZE_BYTE = 4'b0001;
  localparam logic [3:0] MEM_SIZE_HALF = 4'b0010;
  localparam logic [3:0] MEM_SIZE_WORD = 4'b1000;

  typedef enum logic [1:0] {
    MA_IDLE   = 2'd0,
    MA_ACCESS = 2'd1,
    MA_DONE   = 2'd2
  } ma_state_e;

  function automatic logic size_is_legal(input logic [3:0] size);
    return (size == MEM_SIZE_NONE) || (size == MEM_SIZE_BYTE) ||
           (size == MEM_SIZE_HALF) || (size == MEM_SIZE_WORD);
  endfunction

endpackage

// File: rtl/elbeth_mem_access_unit_load_extender.sv
// Picks the addressed byte/half lane out of a bus word and sign- or zero-extends it to 32 bits.
module elbeth_load_extender
  import elbeth_mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [3:0]  size,
  input  logic        sign,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      MEM_SIZE_BYTE: result = {{24{sign & byte_lane[7]}}, byte_lane};
      MEM_SIZE_HALF: result = {{16{sign & half_lane[15]}}, half_lane};
      MEM_SIZE_WORD: result = rdata;
      default:       result = '0;
    endcase
  end

endmodule

// File: rtl/elbeth_mem_access_unit.sv
// MEM-stage data-memory access unit: captures one load/store, drives the word bus, returns extended data.
module elbeth_mem_access_unit
  import elbeth_mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TIMEOUT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_mem_en,
  input  logic                  ex_mem_rw,
  input  logic [3:0]            ex_data_size_mem,
  input  logic                  ex_data_sign_mem,
  input  logic [ADDR_WIDTH-1:0] ex_address,
  input  logic [31:0]           ex_write_data,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_wbe,
  output logic                  dmem_en,
  output logic                  dmem_rw,
  input  logic                  dmem_ready,
  input  logic [31:0]           dmem_rdata,
  output logic [31:0]           mem_read_data,
  output logic                  exs_mem_ready,
  output logic                  mem_misaligned,
  output logic                  mem_fault
);

  localparam logic [TIMEOUT_WIDTH-1:0] TO_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

  ma_state_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0]   dmem_addr_q, dmem_addr_d;
  logic [31:0]             dmem_wdata_q, dmem_wdata_d;
  logic [3:0]              dmem_wbe_q, dmem_wbe_d;
  logic                    dmem_en_q, dmem_en_d;
  logic                    dmem_rw_q, dmem_rw_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    mis_q, mis_d;
  logic                    fault_q, fault_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]              addr_lo_q, addr_lo_d;
  logic [3:0]              size_q, size_d;
  logic                    sign_q, sign_d;

  logic                    req_bad;
  logic                    timeout_hit;
  logic [TIMEOUT_WIDTH-1:0] cnt_inc;
  logic [31:0]             ext_data;

  elbeth_load_extender u_load_extender (
    .rdata   (dmem_rdata),
    .addr_lo (addr_lo_q),
    .size    (size_q),
    .sign    (sign_q),
    .result  (ext_data)
  );

  assign req_bad = !size_is_legal(ex_data_size_mem) ||
                   ((ex_data_size_mem == MEM_SIZE_HALF) && ex_address[0]) ||
                   ((ex_data_size_mem == MEM_SIZE_WORD) && (ex_address[1:0] != 2'b00));
  assign cnt_inc     = cnt_q + TIMEOUT_WIDTH'(1);
  assign timeout_hit = (cnt_inc == TO_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= MA_IDLE;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_wbe_q   <= '0;
      dmem_en_q    <= 1'b0;
      dmem_rw_q    <= 1'b0;
      rdata_q      <= '0;
      mis_q        <= 1'b0;
      fault_q      <= 1'b0;
      cnt_q        <= '0;
      addr_lo_q    <= '0;
      size_q       <= '0;
      sign_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_wbe_q   <= dmem_wbe_d;
      dmem_en_q    <= dmem_en_d;
      dmem_rw_q    <= dmem_rw_d;
      rdata_q      <= rdata_d;
      mis_q        <= mis_d;
      fault_q      <= fault_d;
      cnt_q        <= cnt_d;
      addr_lo_q    <= addr_lo_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MA_IDLE: begin
        if (ex_mem_en) begin
          state_d = (req_bad || (ex_data_size_mem == MEM_SIZE_NONE)) ? MA_DONE : MA_ACCESS;
        end
      end
      MA_ACCESS: if (dmem_ready || timeout_hit) state_d = MA_DONE;
      MA_DONE:   state_d = MA_IDLE;
      default:   state_d = MA_IDLE;
    endcase
  end

  // Datapath next-state: bus fields latched on accept, pulses live only for the DONE cycle.
  always_comb begin
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_wbe_d   = dmem_wbe_q;
    dmem_en_d    = dmem_en_q;
    dmem_rw_d    = dmem_rw_q;
    rdata_d      = rdata_q;
    mis_d        = 1'b0;
    fault_d      = 1'b0;
    cnt_d        = '0;
    addr_lo_d    = addr_lo_q;
    size_d       = size_q;
    sign_d       = sign_q;
    case (state_q)
      MA_IDLE: begin
        if (ex_mem_en) begin
          addr_lo_d = ex_address[1:0];
          size_d    = ex_data_size_mem;
          sign_d    = ex_data_sign_mem;
          rdata_d   = '0;
          mis_d     = req_bad;
          if (!req_bad && (ex_data_size_mem != MEM_SIZE_NONE)) begin
            dmem_addr_d = {ex_address[ADDR_WIDTH-1:2], 2'b00};
            dmem_rw_d   = ex_mem_rw;
            dmem_en_d   = 1'b1;
            case (ex_data_size_mem)
              MEM_SIZE_BYTE: begin
                dmem_wdata_d = {4{ex_write_data[7:0]}};
                dmem_wbe_d   = 4'b0001 << ex_address[1:0];
              end
              MEM_SIZE_HALF: begin
                dmem_wdata_d = {2{ex_write_data[15:0]}};
                dmem_wbe_d   = ex_address[1] ? 4'b1100 : 4'b0011;
              end
              default: begin
                dmem_wdata_d = ex_write_data;
                dmem_wbe_d   = 4'b1111;
              end
            endcase
            if (!ex_mem_rw) dmem_wbe_d = '0;
          end
        end
      end
      MA_ACCESS: begin
        if (dmem_ready) begin
          dmem_en_d = 1'b0;
          if (!dmem_rw_q) rdata_d = ext_data;
        end else if (timeout_hit) begin
          dmem_en_d = 1'b0;
          fault_d   = 1'b1;
          rdata_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (state_q)
      MA_IDLE:   exs_mem_ready = ~ex_mem_en;
      MA_ACCESS: exs_mem_ready = 1'b0;
      default:   exs_mem_ready = 1'b1;
    endcase
  end

  assign dmem_addr      = dmem_addr_q;
  assign dmem_wdata     = dmem_wdata_q;
  assign dmem_wbe       = dmem_wbe_q;
  assign dmem_en        = dmem_en_q;
  assign dmem_rw        = dmem_rw_q;
  assign mem_read_data  = rdata_q;
  assign mem_misaligned = mis_q;
  assign mem_fault      = fault_q;

endmodule

// File: tb/tb_elbeth_mem_access_unit.sv
// Scoreboard bench for elbeth_mem_access_unit: expectations queued at request, checked when DONE appears.
module tb_elbeth_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_en;
  logic        ex_mem_rw;
  logic [3:0]  ex_data_size_mem;
  logic        ex_data_sign_mem;
  logic [31:0] ex_address;
  logic [31:0] ex_write_data;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wbe;
  logic        dmem_en;
  logic        dmem_rw;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_read_data;
  logic        exs_mem_ready;
  logic        mem_misaligned;
  logic        mem_fault;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
    logic        fault;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  elbeth_mem_access_unit #(
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (16),
    .TIMEOUT_WIDTH  (5)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_mem_en        (ex_mem_en),
    .ex_mem_rw        (ex_mem_rw),
    .ex_data_size_mem (ex_data_size_mem),
    .ex_data_sign_mem (ex_data_sign_mem),
    .ex_address       (ex_address),
    .ex_write_data    (ex_write_data),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_wbe         (dmem_wbe),
    .dmem_en          (dmem_en),
    .dmem_rw          (dmem_rw),
    .dmem_ready       (dmem_ready),
    .dmem_rdata       (dmem_rdata),
    .mem_read_data    (mem_read_data),
    .exs_mem_ready    (exs_mem_ready),
    .mem_misaligned   (mem_misaligned),
    .mem_fault        (mem_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference load result: shift the addressed lane down, then extend.
  function automatic logic [31:0] load_model(input logic [31:0] rd, input logic [1:0] a,
                                             input logic [3:0] sz, input logic sg);
    logic [31:0] sh;
    sh = rd >> (a * 8);
    if (sz == 4'b0001) return sg ? 32'($signed(sh[7:0]))  : {24'h0, sh[7:0]};
    if (sz == 4'b0010) begin
      sh = rd >> (a[1] * 16);
      return sg ? 32'($signed(sh[15:0])) : {16'h0, sh[15:0]};
    end
    return rd;
  endfunction

  // delay: ACCESS cycle index (0-based) in which dmem_ready is raised; -1 means never.
  task automatic txn(input string tag, input logic rw, input logic [3:0] sz, input logic sg,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                     input int delay);
    exp_t e, got_e;
    logic legal, mis, bus, fault;
    logic [3:0]  wbe_e;
    logic [31:0] wdata_e;
    int n;
    bit done;
    legal = (sz == 4'b0000) || (sz == 4'b0001) || (sz == 4'b0010) || (sz == 4'b1000);
    mis   = !legal || (sz == 4'b0010 && addr[0]) || (sz == 4'b1000 && addr[1:0] != 2'b00);
    bus   = !mis && (sz != 4'b0000);
    fault = bus && (delay < 0 || delay > 15);
    case (sz)
      4'b0001: begin wdata_e = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        case (addr[1:0]) 2'd0: wbe_e = 4'b0001; 2'd1: wbe_e = 4'b0010;
                         2'd2: wbe_e = 4'b0100; default: wbe_e = 4'b1000; endcase end
      4'b0010: begin wdata_e = {wd[15:0], wd[15:0]}; wbe_e = addr[1] ? 4'b1100 : 4'b0011; end
      default: begin wdata_e = wd; wbe_e = 4'b1111; end
    endcase
    if (!rw) wbe_e = 4'b0000;
    e.mis      = mis;
    e.fault    = fault;
    e.chk_data = (!rw && bus) || fault;
    e.data     = fault ? 32'h0 : load_model(rd, addr[1:0], sz, sg);
    e.lat      = !bus ? 1 : (fault ? 17 : delay + 2);

    @(negedge clk);
    ex_mem_en = 1'b1; ex_mem_rw = rw; ex_data_size_mem = sz; ex_data_sign_mem = sg;
    ex_address = addr; ex_write_data = wd;
    exp_q.push_back(e);
    #1 check({tag, ".stall_req"}, 32'(exs_mem_ready), 32'h0);
    @(posedge clk);
    #1 ex_mem_en = 1'b0;

    n = 0; done = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      dmem_ready = 1'b0;
      dmem_rdata = 32'h5A5A_5A5A;
      n++;
      if (exs_mem_ready) begin
        done = 1;
      end else begin
        if (n == 1) begin
          check({tag, ".en"},   32'(dmem_en), 32'h1);
          check({tag, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
          check({tag, ".rw"},   32'(dmem_rw), 32'(rw));
          check({tag, ".wbe"},  32'(dmem_wbe), 32'(wbe_e));
          if (rw) check({tag, ".wdata"}, dmem_wdata, wdata_e);
        end
        if (n - 1 == delay) begin
          dmem_ready = 1'b1;
          dmem_rdata = rd;
        end
      end
    end
    if (!done) begin
      check({tag, ".done_timeout"}, 32'h0, 32'h1);
      void'(exp_q.pop_front());
      return;
    end
    got_e = exp_q.pop_front();
    check({tag, ".lat"},   32'(n), 32'(got_e.lat));
    check({tag, ".mis"},   32'(mem_misaligned), 32'(got_e.mis));
    check({tag, ".fault"}, 32'(mem_fault), 32'(got_e.fault));
    check({tag, ".en_done"}, 32'(dmem_en), 32'h0);
    if (got_e.chk_data) check({tag, ".data"}, mem_read_data, got_e.data);
    @(negedge clk);
    check({tag, ".pulse_clr"}, {30'h0, mem_misaligned, mem_fault}, 32'h0);
    check({tag, ".idle_rdy"}, 32'(exs_mem_ready), 32'h1);
  endtask

  initial begin
    rst = 1'b0;
    ex_mem_en = 1'b0; ex_mem_rw = 1'b0; ex_data_size_mem = 4'b0000; ex_data_sign_mem = 1'b0;
    ex_address = '0; ex_write_data = '0; dmem_ready = 1'b0; dmem_rdata = '0;
    #12;
    check("rst.ready", 32'(exs_mem_ready), 32'h1);
    check("rst.bus", {27'h0, dmem_en, dmem_rw, 3'b000} | 32'(dmem_wbe), 32'h0);
    check("rst.addr", dmem_addr, 32'h0);
    check("rst.wdata", dmem_wdata, 32'h0);
    check("rst.rdata", mem_read_data, 32'h0);
    check("rst.pulses", {30'h0, mem_misaligned, mem_fault}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    txn("lw",       1'b0, 4'b1000, 1'b0, 32'h100, 32'h0, 32'h89AB_CDEF, 0);
    txn("lb",       1'b0, 4'b0001, 1'b1, 32'h103, 32'h0, 32'h80FF_FFFF, 0);
    txn("lbu",      1'b0, 4'b0001, 1'b0, 32'h103, 32'h0, 32'h80FF_FFFF, 1);
    txn("lh",       1'b0, 4'b0010, 1'b1, 32'h102, 32'h0, 32'h8001_1234, 0);
    txn("lhu",      1'b0, 4'b0010, 1'b0, 32'h100, 32'h0, 32'h1234_F00D, 3);
    txn("sb",       1'b1, 4'b0001, 1'b0, 32'h101, 32'h0000_00A5, 32'h0, 0);
    txn("sh",       1'b1, 4'b0010, 1'b0, 32'h102, 32'h0000_BEEF, 32'h0, 2);
    txn("sw",       1'b1, 4'b1000, 1'b0, 32'h200, 32'hDEAD_BEEF, 32'h0, 0);
    txn("lw_mis",   1'b0, 4'b1000, 1'b0, 32'h102, 32'h0, 32'h0, 0);
    txn("sz_ill",   1'b0, 4'b0100, 1'b0, 32'h100, 32'h0, 32'h0, 0);
    txn("lh_mis",   1'b0, 4'b0010, 1'b0, 32'h101, 32'h0, 32'h0, 0);
    txn("sz_none",  1'b0, 4'b0000, 1'b0, 32'h100, 32'h0, 32'h0, 0);
    txn("timeout",  1'b0, 4'b1000, 1'b0, 32'h300, 32'h0, 32'h1111_1111, -1);
    txn("rdy_edge", 1'b0, 4'b1000, 1'b0, 32'h304, 32'h0, 32'h2222_3333, 15);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, r;
      logic [3:0]  s;
      a = {20'h0, 12'($urandom_range(0, 4095))};
      r = $urandom;
      case ($urandom_range(0, 2)) 0: s = 4'b0001; 1: s = 4'b0010; default: s = 4'b1000; endcase
      txn("rnd", 1'b0, s, 1'($urandom_range(0, 1)), a, 32'h0, r, int'($urandom_range(0, 4)));
    end

    // Async reset three cycles into ACCESS.
    @(negedge clk);
    ex_mem_en = 1'b1; ex_mem_rw = 1'b0; ex_data_size_mem = 4'b1000; ex_address = 32'h400;
    @(posedge clk);
    #1 ex_mem_en = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid.en_before", 32'(dmem_en), 32'h1);
    rst = 1'b0;
    #1;
    check("rst_mid.en", 32'(dmem_en), 32'h0);
    check("rst_mid.ready", 32'(exs_mem_ready), 32'h1);
    check("rst_mid.pulses", {30'h0, mem_misaligned, mem_fault}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid.quiet", {29'h0, dmem_en, mem_misaligned, mem_fault}, 32'h0);
    txn("post_rst", 1'b0, 4'b0001, 1'b1, 32'h401, 32'h0, 32'h0000_F700, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
